meas_sequencer: RTL and testbench

//  Top-level measurement sequencer for N measurement units plus one transmit unit.

---
 rtl/meas_pkg.sv | 34 +++
 rtl/seq_timer.sv | 33 +++
 rtl/meas_sequencer.sv | 133 +++++++++++++
 tb/tb_meas_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/meas_pkg.sv
// Shared types and constants for the measurement sequencer:
// FSM state encoding, timeout phase codes and the all-units-off mask.
package meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_MEAS,
    ST_WAIT_MEAS,
    ST_START_TX,
    ST_WAIT_TX,
    ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    S_MEAS_START = 2'd0,
    S_MEAS_WAIT  = 2'd1,
    S_TX_START   = 2'd2,
    S_TX_WAIT    = 2'd3
  } stage_t;

  localparam int MAX_UNITS = 32;
  localparam logic [MAX_UNITS-1:0] MASK_NONE = '0;

  // Phase reported when the given active state runs out of time.
  function automatic stage_t stage_of(input state_t s);
    case (s)
      ST_WAIT_MEAS: stage_of = S_MEAS_WAIT;
      ST_START_TX:  stage_of = S_TX_START;
      ST_WAIT_TX:   stage_of = S_TX_WAIT;
      default:      stage_of = S_MEAS_START;
    endcase
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Per-phase cycle counter: cleared on every state entry, counts while enabled,
// flags expiry on the cycle the count reaches the limit. A zero limit never expires.
module seq_timer #(
  parameter int TO_W = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            enable,
  input  logic [TO_W-1:0] limit,
  output logic            expired
);

  localparam logic [TO_W-1:0] ONE = {{(TO_W-1){1'b0}}, 1'b1};

  logic [TO_W-1:0] r_count;
  logic            w_at_limit;

  // The count holds (limit-1) during the limit-th cycle of the phase.
  assign w_at_limit = (limit != '0) && (r_count >= (limit - ONE));
  assign expired    = enable && w_at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != '1)) begin
      r_count <= r_count + ONE;
    end
  end

endmodule

// File: rtl/meas_sequencer.sv
// Measurement sequencer: starts the masked units, waits for them, then runs the
// transmitter; supports repeat mode, per-phase timeouts, abort and sticky errors.
module meas_sequencer
  import meas_pkg::*;
#(
  parameter int N_UNITS = 2,
  parameter int TO_W    = 24,
  parameter int ITER_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [N_UNITS-1:0] cmd_mask,
  input  logic               cmd_repeat,
  input  logic               abort,
  input  logic               err_clr,
  input  logic [TO_W-1:0]    timeout_cycles,
  output logic [N_UNITS-1:0] unit_start,
  input  logic [N_UNITS-1:0] unit_busy,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic [N_UNITS-1:0] mode,
  output logic               busy,
  output logic               done,
  output logic [ITER_W-1:0]  iter_count,
  output logic               err,
  output logic [1:0]         err_stage
);

  localparam logic [ITER_W-1:0] ITER_ONE = {{(ITER_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_state_next;
  logic [N_UNITS-1:0] r_mask;
  logic               r_repeat;
  logic [ITER_W-1:0]  r_iter;
  stage_t             r_err_stage;
  logic               r_done;

  logic [N_UNITS-1:0] w_mask_none;
  logic [N_UNITS-1:0] w_busy_masked;
  logic               w_accept;
  logic               w_active;
  logic               w_expired;
  logic               w_timeout;
  logic               w_iter_done;

  assign w_mask_none   = MASK_NONE[N_UNITS-1:0];
  assign w_busy_masked = unit_busy & r_mask;
  assign w_accept      = cmd_valid && cmd_ready;
  assign w_active      = (r_state == ST_START_MEAS) || (r_state == ST_WAIT_MEAS) ||
                         (r_state == ST_START_TX)   || (r_state == ST_WAIT_TX);

  seq_timer #(.TO_W(TO_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_state_next != r_state),
    .enable  (w_active),
    .limit   (timeout_cycles),
    .expired (w_expired)
  );

  // Abort beats timeout, which beats the normal handshake progression.
  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    w_iter_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (cmd_mask != w_mask_none)) w_state_next = ST_START_MEAS;
      end
      ST_ERROR: begin
        if (err_clr || abort) w_state_next = ST_IDLE;
      end
      default: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else if (w_expired) begin
          w_state_next = ST_ERROR;
          w_timeout    = 1'b1;
        end else begin
          case (r_state)
            ST_START_MEAS: if (w_busy_masked == r_mask)      w_state_next = ST_WAIT_MEAS;
            ST_WAIT_MEAS:  if (w_busy_masked == w_mask_none) w_state_next = ST_START_TX;
            ST_START_TX:   if (tx_busy)                      w_state_next = ST_WAIT_TX;
            ST_WAIT_TX: begin
              if (!tx_busy) begin
                w_iter_done  = 1'b1;
                w_state_next = r_repeat ? ST_START_MEAS : ST_IDLE;
              end
            end
            default: w_state_next = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_repeat    <= 1'b0;
      r_iter      <= '0;
      r_err_stage <= S_MEAS_START;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_iter_done;
      if (w_accept) begin
        r_mask      <= cmd_mask;
        r_repeat    <= cmd_repeat;
        r_iter      <= '0;
        r_err_stage <= S_MEAS_START;
      end else begin
        if (w_iter_done && (r_iter != '1)) r_iter <= r_iter + ITER_ONE;
        if (w_timeout) r_err_stage <= stage_of(r_state);
      end
    end
  end

  assign cmd_ready  = (r_state == ST_IDLE) && !abort;
  assign unit_start = (r_state == ST_START_MEAS) ? r_mask : w_mask_none;
  assign tx_start   = (r_state == ST_START_TX);
  assign mode       = r_mask;
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign iter_count = r_iter;
  assign err        = (r_state == ST_ERROR);
  assign err_stage  = r_err_stage;

endmodule

// File: tb/tb_meas_sequencer.sv
// Self-checking bench for meas_sequencer: scripted unit/tx busy responses,
// a done-pulse scoreboard and inline checks per scenario.
module tb_meas_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mask;
  logic        cmd_repeat;
  logic        abort;
  logic        err_clr;
  logic [23:0] timeout_cycles;
  logic [1:0]  unit_start;
  logic [1:0]  unit_busy;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [15:0] iter_count;
  logic        err;
  logic [1:0]  err_stage;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int obs_q[$];
  int exp_q[$];

  meas_sequencer #(.N_UNITS(2), .TO_W(24), .ITER_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mask(cmd_mask), .cmd_repeat(cmd_repeat), .abort(abort), .err_clr(err_clr),
    .timeout_cycles(timeout_cycles), .unit_start(unit_start), .unit_busy(unit_busy),
    .tx_start(tx_start), .tx_busy(tx_busy), .mode(mode), .busy(busy), .done(done),
    .iter_count(iter_count), .err(err), .err_stage(err_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record iter_count at every done pulse for the scoreboard.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      obs_q.push_back(int'(iter_count));
      done_cnt++;
    end
  end

  // Present a command for one edge; returns at the first START_MEAS negedge.
  task automatic send_cmd(input logic [1:0] m, input logic rep);
    cmd_valid  = 1'b1;
    cmd_mask   = m;
    cmd_repeat = rep;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({cmd_ready, busy, tx_start, done, err} !== 5'b10000) begin
      bad++; $display("FAIL reset_flags: got %b want 10000", {cmd_ready, busy, tx_start, done, err});
    end
    total++;
    if ({unit_start, mode, err_stage, iter_count} !== 22'd0) begin
      bad++; $display("FAIL reset_values: got %h want 0", {unit_start, mode, err_stage, iter_count});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    int e, o;
    send_cmd(2'b10, 1'b0);
    exp_q.push_back(1);
    total++;
    if (unit_start !== 2'b10 || mode !== 2'b10 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      bad++; $display("FAIL single_start: got start=%b mode=%b busy=%b ready=%b want 10 10 1 0",
                      unit_start, mode, busy, cmd_ready);
    end
    repeat (2) begin
      @(negedge clk);
      total++;
      if (unit_start !== 2'b10) begin bad++; $display("FAIL single_start_hold: got %b want 10", unit_start); end
    end
    unit_busy = 2'b11;  // unit0 is unmasked and stays busy throughout
    @(negedge clk);
    total++;
    if (unit_start !== 2'b00) begin bad++; $display("FAIL single_start_drop: got %b want 00", unit_start); end
    repeat (9) @(negedge clk);
    unit_busy = 2'b01;
    @(negedge clk);
    total++;
    if (tx_start !== 1'b1) begin bad++; $display("FAIL single_tx_start: got %b want 1", tx_start); end
    tx_busy = 1'b1;
    @(negedge clk);
    total++;
    if (tx_start !== 1'b0) begin bad++; $display("FAIL single_tx_drop: got %b want 0", tx_start); end
    repeat (4) @(negedge clk);
    tx_busy   = 1'b0;
    unit_busy = 2'b00;
    @(negedge clk);
    total++;
    if (done !== 1'b1 || iter_count !== 16'd1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL single_end: got done=%b iter=%0d busy=%b ready=%b want 1 1 0 1",
                      done, iter_count, busy, cmd_ready);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL single_done_width: got %b want 0", done); end
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL sb_single: got no done want iter=%0d", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL sb_single: got iter=%0d want %0d", o, e); end end
    end
    total++;
    if (obs_q.size() != 0) begin bad++; $display("FAIL sb_single_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_two_units;
    int e, o;
    send_cmd(2'b11, 1'b0);
    exp_q.push_back(1);
    @(negedge clk);
    unit_busy = 2'b01;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (unit_start !== 2'b11) begin bad++; $display("FAIL two_start_hold: got %b want 11", unit_start); end
    end
    unit_busy = 2'b11;
    @(negedge clk);
    total++;
    if (unit_start !== 2'b00) begin bad++; $display("FAIL two_wait_meas: got %b want 00", unit_start); end
    unit_busy = 2'b10;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (tx_start !== 1'b0) begin bad++; $display("FAIL two_tx_early: got %b want 0", tx_start); end
    end
    unit_busy = 2'b00;
    @(negedge clk);
    total++;
    if (tx_start !== 1'b1) begin bad++; $display("FAIL two_tx_start: got %b want 1", tx_start); end
    tx_busy = 1'b1;
    @(negedge clk);
    tx_busy = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b1 || iter_count !== 16'd1) begin
      bad++; $display("FAIL two_done: got done=%b iter=%0d want 1 1", done, iter_count);
    end
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL sb_two: got no done want iter=%0d", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL sb_two: got iter=%0d want %0d", o, e); end end
    end
    total++;
    if (obs_q.size() != 0) begin bad++; $display("FAIL sb_two_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_timeout;
    int base;
    base = done_cnt;
    timeout_cycles = 24'd8;
    send_cmd(2'b01, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (err !== 1'b0 || unit_start !== 2'b01) begin
        bad++; $display("FAIL to_meas_early: cycle %0d got err=%b start=%b want 0 01", i + 1, err, unit_start);
      end
    end
    @(negedge clk);
    total++;
    if (err !== 1'b1 || err_stage !== 2'd0 || cmd_ready !== 1'b0 || unit_start !== 2'b00 || busy !== 1'b1) begin
      bad++; $display("FAIL to_meas_err: got err=%b stage=%0d ready=%b start=%b busy=%b want 1 0 0 00 1",
                      err, err_stage, cmd_ready, unit_start, busy);
    end
    repeat (3) @(negedge clk);
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++;
    if (err !== 1'b0 || cmd_ready !== 1'b1 || err_stage !== 2'd0) begin
      bad++; $display("FAIL to_clear: got err=%b ready=%b stage=%0d want 0 1 0", err, cmd_ready, err_stage);
    end
    send_cmd(2'b01, 1'b0);
    unit_busy = 2'b01;
    @(negedge clk);
    unit_busy = 2'b00;
    @(negedge clk);
    tx_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL to_tx_early: cycle %0d got err=%b want 0", i + 1, err); end
    end
    @(negedge clk);
    total++;
    if (err !== 1'b1 || err_stage !== 2'd3) begin
      bad++; $display("FAIL to_tx_err: got err=%b stage=%0d want 1 3", err, err_stage);
    end
    abort = 1'b1;
    @(negedge clk);
    abort   = 1'b0;
    tx_busy = 1'b0;
    total++;
    if (err !== 1'b0 || busy !== 1'b0 || err_stage !== 2'd3) begin
      bad++; $display("FAIL to_abort_clear: got err=%b busy=%b stage=%0d want 0 0 3", err, busy, err_stage);
    end
    total++;
    if (done_cnt != base) begin bad++; $display("FAIL to_no_done: got %0d done want 0", done_cnt - base); end
    timeout_cycles = 24'd1000;
  endtask

  task automatic test_repeat_abort;
    int e, o, base;
    base = done_cnt;
    send_cmd(2'b01, 1'b1);
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    for (int it = 0; it < 4; it++) begin
      total++;
      if (unit_start !== 2'b01) begin bad++; $display("FAIL rep_start: iter %0d got %b want 01", it, unit_start); end
      unit_busy = 2'b01;
      @(negedge clk);
      if (it == 3) break;
      unit_busy = 2'b00;
      @(negedge clk);
      tx_busy = 1'b1;
      @(negedge clk);
      tx_busy = 1'b0;
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || unit_start !== 2'b00 || iter_count !== 16'd3 || cmd_ready !== 1'b0) begin
      bad++; $display("FAIL rep_abort: got busy=%b start=%b iter=%0d ready=%b want 0 00 3 0",
                      busy, unit_start, iter_count, cmd_ready);
    end
    abort     = 1'b0;
    unit_busy = 2'b00;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rep_ready: got %b want 1", cmd_ready); end
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (done_cnt - base != 3) begin bad++; $display("FAIL rep_done_count: got %0d want 3", done_cnt - base); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL sb_rep: got no done want iter=%0d", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL sb_rep: got iter=%0d want %0d", o, e); end end
    end
    total++;
    if (obs_q.size() != 0) begin bad++; $display("FAIL sb_rep_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_idle_cases;
    int base;
    bit saw_err;
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_mask  = 2'b01;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || unit_start !== 2'b00 || cmd_ready !== 1'b0) begin
      bad++; $display("FAIL idle_abort_block: got busy=%b start=%b ready=%b want 0 00 0", busy, unit_start, cmd_ready);
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    base = done_cnt;
    send_cmd(2'b00, 1'b0);
    total++;
    if (busy !== 1'b0 || unit_start !== 2'b00 || iter_count !== 16'd0 || mode !== 2'b00) begin
      bad++; $display("FAIL idle_zero_mask: got busy=%b start=%b iter=%0d mode=%b want 0 00 0 00",
                      busy, unit_start, iter_count, mode);
    end
    repeat (2) @(negedge clk);
    total++;
    if (done_cnt != base) begin bad++; $display("FAIL idle_zero_done: got %0d done want 0", done_cnt - base); end
    timeout_cycles = 24'd0;
    send_cmd(2'b01, 1'b0);
    unit_busy = 2'b01;
    saw_err = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (err !== 1'b0) saw_err = 1'b1;
    end
    total++;
    if (saw_err || busy !== 1'b1) begin
      bad++; $display("FAIL idle_to_disabled: got err_seen=%b busy=%b want 0 1", saw_err, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort     = 1'b0;
    unit_busy = 2'b00;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_stuck_abort: got busy=%b want 0", busy); end
    timeout_cycles = 24'd1000;
  endtask

  task automatic test_reset_mid;
    int e, o, base;
    send_cmd(2'b01, 1'b1);
    exp_q.push_back(1);
    for (int it = 0; it < 2; it++) begin
      unit_busy = 2'b01;
      @(negedge clk);
      unit_busy = 2'b00;
      @(negedge clk);
      tx_busy = 1'b1;
      @(negedge clk);
      if (it == 0) begin
        tx_busy = 1'b0;
        @(negedge clk);
      end
    end
    total++;
    if (iter_count !== 16'd1 || busy !== 1'b1) begin
      bad++; $display("FAIL rst_pre: got iter=%0d busy=%b want 1 1", iter_count, busy);
    end
    #1;
    base = done_cnt;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({cmd_ready, busy, tx_start, done, err} !== 5'b10000 ||
        {unit_start, mode, err_stage, iter_count} !== 22'd0) begin
      bad++; $display("FAIL rst_async: got flags=%b vals=%h want 10000 0",
                      {cmd_ready, busy, tx_start, done, err}, {unit_start, mode, err_stage, iter_count});
    end
    @(negedge clk);
    tx_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (done_cnt != base || busy !== 1'b0) begin
      bad++; $display("FAIL rst_no_done: got done=%0d busy=%b want 0 0", done_cnt - base, busy);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL sb_rst: got no done want iter=%0d", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL sb_rst: got iter=%0d want %0d", o, e); end end
    end
    total++;
    if (obs_q.size() != 0) begin bad++; $display("FAIL sb_rst_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    rst_n          = 1'b0;
    cmd_valid      = 1'b0;
    cmd_mask       = 2'b00;
    cmd_repeat     = 1'b0;
    abort          = 1'b0;
    err_clr        = 1'b0;
    timeout_cycles = 24'd1000;
    unit_busy      = 2'b00;
    tx_busy        = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_two_units();
    test_timeout();
    test_repeat_abort();
    test_idle_cases();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
